// File: rtl/sram_reader_pkg.sv
// Shared types for the pixel SRAM frame reader: FSM state encoding, FIFO word, border address.
package sram_reader_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;

    localparam int unsigned PX_DATA_WIDTH = 32;

    // Sliced down to the address width by users; the SRAM returns 0 at this address.
    localparam logic [63:0] ALL_ONES_ADDR = '1;

    typedef struct packed {
        logic [PX_DATA_WIDTH-1:0] data;
        logic                     eol;
        logic                     last;
    } px_word_t;

endpackage

// File: rtl/sram_reader_fifo.sv
// Synchronous output FIFO of tagged pixel words; simultaneous push and pop are allowed.
module sram_reader_fifo
    import sram_reader_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  px_word_t      i_wdata,
    input  logic          i_pop,
    output px_word_t      o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    px_word_t      r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= next_ptr(r_wptr);
            end
            if (i_pop) r_rptr <= next_ptr(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_frame_reader.sv
// Raster-order frame fetch from a 1-cycle-latency SRAM onto a valid/ready pixel stream.
// Optional PAD_BORDER_EN wraps the frame in a 1-pixel zero border read from the all-ones address.
module sram_frame_reader
    import sram_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  img_w,
    input  logic [DIM_WIDTH-1:0]  img_h,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ren,
    output logic                  sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_rdat,
    output logic [DATA_WIDTH-1:0] px_data,
    output logic                  px_valid,
    input  logic                  px_ready,
    output logic                  px_eol,
    output logic                  px_last
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONES = ALL_ONES_ADDR[ADDR_WIDTH-1:0];

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DIM_WIDTH-1:0]  r_col;
    logic [DIM_WIDTH-1:0]  r_row;
    logic [DIM_WIDTH-1:0]  r_col_last;
    logic [DIM_WIDTH-1:0]  r_row_last;
    logic                  r_inflight;
    logic                  r_if_eol;
    logic                  r_if_last;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_empty;
    px_word_t      w_head;
    px_word_t      w_push_word;
    logic          w_ren;
    logic          w_pop;
    logic          w_eol;
    logic          w_last;
    logic          w_border;

`ifdef PAD_BORDER_EN
    assign w_border = (r_col == '0) || (r_col == r_col_last) ||
                      (r_row == '0) || (r_row == r_row_last);
`else
    assign w_border = 1'b0;
`endif

    // Counting the in-flight read keeps the FIFO from ever being pushed while full.
    assign w_ren  = (r_state == READ) &&
                    (({1'b0, w_fifo_count} + (CW+1)'(r_inflight)) < (CW+1)'(FIFO_DEPTH));
    assign w_eol  = (r_col == r_col_last);
    assign w_last = w_eol && (r_row == r_row_last);
    assign w_pop  = px_valid && px_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_col_last <= '0;
            r_row_last <= '0;
            r_inflight <= 1'b0;
            r_if_eol   <= 1'b0;
            r_if_last  <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            r_if_eol   <= w_eol;
            r_if_last  <= w_last;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (img_w != '0 && img_h != '0) begin
                            r_state <= READ;
                            r_addr  <= base_addr;
                            r_col   <= '0;
                            r_row   <= '0;
`ifdef PAD_BORDER_EN
                            r_col_last <= img_w + DIM_WIDTH'(1);
                            r_row_last <= img_h + DIM_WIDTH'(1);
`else
                            r_col_last <= img_w - DIM_WIDTH'(1);
                            r_row_last <= img_h - DIM_WIDTH'(1);
`endif
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (w_ren) begin
                        if (w_eol) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_WIDTH'(1);
                        end else begin
                            r_col <= r_col + DIM_WIDTH'(1);
                        end
                        if (!w_border) r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_inflight &&
                        (w_fifo_count == '0 || (w_fifo_count == CW'(1) && w_pop)))
                        r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push_word = '{data: sram_rdat, eol: r_if_eol, last: r_if_last};

    sram_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_wdata (w_push_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign sram_ren  = w_ren;
    assign sram_wen  = 1'b0;
    assign sram_addr = ((r_state == READ) && w_border) ? ADDR_ONES : r_addr;
    assign px_valid  = !w_fifo_empty;
    assign px_data   = w_head.data;
    assign px_eol    = w_head.eol;
    assign px_last   = w_head.last;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with a behavioural 1-cycle-latency SRAM.
`timescale 1ns/1ps
module tb_sram_frame_reader;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 12;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [WW-1:0] img_w;
    logic [WW-1:0] img_h;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_addr;
    logic          sram_ren;
    logic          sram_wen;
    logic [DW-1:0] sram_rdat = '0;
    logic [DW-1:0] px_data;
    logic          px_valid;
    logic          px_ready;
    logic          px_eol;
    logic          px_last;

    sram_frame_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DIM_WIDTH  (WW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .img_w     (img_w),
        .img_h     (img_h),
        .busy      (busy),
        .done      (done),
        .sram_addr (sram_addr),
        .sram_ren  (sram_ren),
        .sram_wen  (sram_wen),
        .sram_rdat (sram_rdat),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_eol    (px_eol),
        .px_last   (px_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM contents: word = address - 0x1F, so 0x20..0x23 hold 1..4; all-ones reads 0.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == '1) return '0;
        return DW'(a) - DW'(32'h1F);
    endfunction

    always @(posedge clk) if (sram_ren) sram_rdat <= mem_word(sram_addr);

    logic          rnd_ready = 1'b0;
    initial begin
        px_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            px_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [DW-1:0] q_data [$];
    logic          q_eol  [$];
    logic          q_last [$];
    logic [AW-1:0] q_addr [$];
    int cyc = 0, done_n = 0, done_cyc = 0, last_cyc = 0, max_occ = 0;

    always @(negedge clk) begin
        int occ;
        cyc++;
        if (!rst) begin
            if (px_valid && px_ready) begin
                q_data.push_back(px_data);
                q_eol.push_back(px_eol);
                q_last.push_back(px_last);
                if (px_last) last_cyc = cyc;
            end
            if (sram_ren) q_addr.push_back(sram_addr);
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            occ = int'(dut.w_fifo_count) + int'(dut.r_inflight);
            if (occ > max_occ) max_occ = occ;
        end
    end

    logic [DW-1:0] e_data [$];
    logic          e_eol  [$];
    logic          e_last [$];
    logic [AW-1:0] e_addr [$];

    task automatic build_exp(input logic [AW-1:0] base, input int w, input int h);
        int pad, pw, ph;
        logic [AW-1:0] a;
        logic brd;
`ifdef PAD_BORDER_EN
        pad = 1;
`else
        pad = 0;
`endif
        pw = w + 2 * pad;
        ph = h + 2 * pad;
        a  = base;
        e_data.delete(); e_eol.delete(); e_last.delete(); e_addr.delete();
        for (int r = 0; r < ph; r++) begin
            for (int c = 0; c < pw; c++) begin
                brd = (pad != 0) && (r == 0 || c == 0 || r == ph - 1 || c == pw - 1);
                if (brd) begin
                    e_addr.push_back('1);
                    e_data.push_back('0);
                end else begin
                    e_addr.push_back(a);
                    e_data.push_back(mem_word(a));
                    a = a + AW'(1);
                end
                e_eol.push_back(c == pw - 1);
                e_last.push_back((c == pw - 1) && (r == ph - 1));
            end
        end
    endtask

    task automatic clear_obs();
        q_data.delete(); q_eol.delete(); q_last.delete(); q_addr.delete();
        done_n  = 0;
        max_occ = 0;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, ".npx"}, q_data.size(), e_data.size());
        check({tag, ".nrd"}, q_addr.size(), e_addr.size());
        for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
            check($sformatf("%s.data[%0d]", tag, i), q_data[i], e_data[i]);
            check($sformatf("%s.eol[%0d]", tag, i), q_eol[i], e_eol[i]);
            check($sformatf("%s.last[%0d]", tag, i), q_last[i], e_last[i]);
        end
        for (int i = 0; i < e_addr.size() && i < q_addr.size(); i++)
            check($sformatf("%s.addr[%0d]", tag, i), q_addr[i], e_addr[i]);
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input int w, input int h);
        @(posedge clk); #1;
        base_addr = b;
        img_w     = WW'(w);
        img_h     = WW'(h);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_n == 0; i++) @(posedge clk);
        check({tag, ".done_seen"}, done_n > 0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_pixels(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && q_data.size() < n; i++) begin
            @(posedge clk); #1;
        end
        check({tag, ".reach"}, q_data.size() >= n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        int n_ones;
        rst = 1'b1; start = 1'b0; base_addr = '0; img_w = '0; img_h = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.px_valid", px_valid, 1'b0);
        check("rst.sram_ren", sram_ren, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.sram_wen", sram_wen, 1'b0);
        check("rst.sram_addr", sram_addr, '0);
        check("rst.px_data", px_data, '0);
        check("rst.px_eol", px_eol, 1'b0);
        check("rst.px_last", px_last, 1'b0);
        rst = 1'b0;

        // 4x3 at 0x100, consumer always ready
        clear_obs();
        rnd_ready = 1'b0;
        build_exp(18'h100, 4, 3);
        start_frame(18'h100, 4, 3);
        check("t1.busy", busy, 1'b1);
        check("t1.ren_E0", sram_ren, 1'b1);
        check("t1.valid_E0", px_valid, 1'b0);
        @(posedge clk); #1;
        check("t1.valid_E1", px_valid, 1'b0);
        @(posedge clk); #1;
        check("t1.valid_E2", px_valid, 1'b1);
        wait_done("t1", 300);
        compare_frame("t1");
        check("t1.done_n", done_n, 1);
        check("t1.done_lat", done_cyc - last_cyc, 1);
        check("t1.idle_busy", busy, 1'b0);

        // same frame, random backpressure
        clear_obs();
        rnd_ready = 1'b1;
        start_frame(18'h100, 4, 3);
        wait_done("t2", 600);
        compare_frame("t2");
        check("t2.done_n", done_n, 1);
        check("t2.done_lat", done_cyc - last_cyc, 1);
        check("t2.occ_max", max_occ <= int'(FD), 1'b1);
        rnd_ready = 1'b0;

        // zero-width frame
        clear_obs();
        start_frame(18'h500, 0, 5);
        sc = cyc;
        wait_done("t3", 20);
        check("t3.nrd", q_addr.size(), 0);
        check("t3.npx", q_data.size(), 0);
        check("t3.done_n", done_n, 1);
        check("t3.done_lat", done_cyc - sc, 1);

        // reset after 5th pixel of 8x8, then fresh 2x2
        clear_obs();
        start_frame(18'h200, 8, 8);
        wait_pixels("t4", 5, 300);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t4.abort_valid", px_valid, 1'b0);
        check("t4.abort_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4.no_done", done_n, 0);
        clear_obs();
        build_exp(18'h300, 2, 2);
        start_frame(18'h300, 2, 2);
        wait_done("t4", 300);
        compare_frame("t4");
        check("t4.done_n", done_n, 1);

        // start pulse mid-frame is ignored
        clear_obs();
        build_exp(18'h400, 4, 4);
        start_frame(18'h400, 4, 4);
        wait_pixels("t5", 3, 300);
        base_addr = '0; img_w = WW'(2); img_h = WW'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5", 300);
        compare_frame("t5");
        check("t5.done_n", done_n, 1);

`ifdef PAD_BORDER_EN
        // padded 2x2 at 0x20 holding 1..4
        clear_obs();
        build_exp(18'h20, 2, 2);
        start_frame(18'h20, 2, 2);
        wait_done("t6", 300);
        compare_frame("t6");
        n_ones = 0;
        foreach (q_addr[i]) if (q_addr[i] == '1) n_ones++;
        check("t6.border_reads", n_ones, 12);
        check("t6.done_n", done_n, 1);
`else
        n_ones = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
